// File: rtl/time_display_scan_pkg.sv
// Shared constants for the time display scanner: segment patterns and
// set-field select codes, plus a helper that maps a digit slot to its field.
package time_display_scan_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // All digit enables off (active-low)
    localparam logic [5:0] AN_OFF    = 6'b111111;

    // Highest legal scan index (hours tens)
    localparam logic [2:0] IDX_LAST  = 3'd5;

    // Which field the operator is currently setting
    typedef enum logic [1:0] {
        SEL_RUN = 2'b00,
        SEL_SEC = 2'b01,
        SEL_MIN = 2'b10,
        SEL_HR  = 2'b11
    } set_sel_e;

    // Digit slots pair up into fields: 0-1 seconds, 2-3 minutes, 4-5 hours
    function automatic set_sel_e field_of_idx(input logic [2:0] idx);
        set_sel_e field;
        if (idx <= 3'd1) begin
            field = SEL_SEC;
        end else if (idx <= 3'd3) begin
            field = SEL_MIN;
        end else if (idx <= 3'd5) begin
            field = SEL_HR;
        end else begin
            field = SEL_RUN;
        end
        return field;
    endfunction

endpackage

// File: rtl/time_display_scan_seg7.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import time_display_scan_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup, anything above 9 is rendered as a dash
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// Six-digit multiplexed common-anode display driver for HH.MM.SS with a
// once-per-frame snapshot of the time and blinking of the field being set.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       cr,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [1:0] clock_set_select,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_prescaler;
    logic [2:0]    r_idx;
    logic [FW-1:0] r_frame;
    logic          r_blinkOn;
    logic [23:0]   r_snapshot;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic          w_tick;
    logic          w_wrap;
    logic          w_idxInvalid;
    logic [2:0]    w_idxNext;
    logic          w_frameLast;
    logic          w_blinkNext;
    logic          w_blank;
    logic [3:0]    w_nibble;
    logic [6:0]    w_segDigit;
    logic [5:0]    w_anNext;
    logic          w_dpNext;

    // Tick, wrap and next-slot decisions, including the blink state that the
    // new frame will see so a toggle applies from its very first digit
    always_comb begin
        w_tick       = (r_prescaler == PRE_LAST);
        w_idxInvalid = (r_idx > IDX_LAST);
        w_wrap       = w_tick && (r_idx == IDX_LAST);
        w_idxNext    = (r_idx >= IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        w_frameLast  = (r_frame == FRAME_LAST);
        w_blinkNext  = (w_wrap && w_frameLast) ? ~r_blinkOn : r_blinkOn;
        w_anNext     = ~(6'b000001 << w_idxNext);
        w_dpNext     = !((w_idxNext == 3'd2) || (w_idxNext == 3'd4));
        w_blank      = !w_blinkNext
                       && (set_sel_e'(clock_set_select) != SEL_RUN)
                       && (field_of_idx(w_idxNext) == set_sel_e'(clock_set_select));
    end

    // Pick the nibble for the upcoming slot; on a wrap digit 0 comes straight
    // from the live seconds so it matches the snapshot being taken
    always_comb begin
        w_nibble = r_snapshot[3:0];
        case (w_idxNext)
            3'd0:    w_nibble = w_wrap ? second[3:0] : r_snapshot[3:0];
            3'd1:    w_nibble = r_snapshot[7:4];
            3'd2:    w_nibble = r_snapshot[11:8];
            3'd3:    w_nibble = r_snapshot[15:12];
            3'd4:    w_nibble = r_snapshot[19:16];
            3'd5:    w_nibble = r_snapshot[23:20];
            default: w_nibble = r_snapshot[3:0];
        endcase
    end

    bcd_to_seg7 u_bcdToSeg7 (
        .i_bcd (w_nibble),
        .o_seg (w_segDigit)
    );

    // Prescaler and scan index advance together on each tick
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_prescaler <= '0;
            r_idx       <= 3'd0;
        end else if (w_tick) begin
            r_prescaler <= '0;
            r_idx       <= w_idxNext;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
        end
    end

    // Per-frame state: snapshot, frame counter and blink phase update on wrap
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_snapshot <= 24'h0;
            r_frame    <= '0;
            r_blinkOn  <= 1'b1;
        end else if (w_wrap) begin
            r_snapshot <= {hour, minute, second};
            r_frame    <= w_frameLast ? '0 : r_frame + FW'(1);
            r_blinkOn  <= w_blinkNext;
        end
    end

    // Registered display outputs, reloaded only on tick edges
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_tick) begin
            if (w_idxInvalid) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else if (w_blank) begin
                r_an  <= w_anNext;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= w_anNext;
                r_seg <= w_segDigit;
                r_dp  <= w_dpNext;
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_time_display_scan.sv
// Bench for time_display_scan: a tick-counting reference model predicts the
// display from elapsed clock edges and the time captured at each frame start.
module tb_time_display_scan;

    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;

    logic       clk = 1'b0;
    logic       cr = 1'b1;
    logic [7:0] hour = 8'h00;
    logic [7:0] minute = 8'h00;
    logic [7:0] second = 8'h00;
    logic [1:0] sel = 2'b00;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    time_display_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk              (clk),
        .cr               (cr),
        .hour             (hour),
        .minute           (minute),
        .second           (second),
        .clock_set_select (sel),
        .an               (an),
        .seg              (seg),
        .dp               (dp)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    // Reference model: counts edges since reset, derives slot/frame/blink
    // phase arithmetically and decodes from its own pattern table
    logic [6:0]  digitPattern [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                       7'b0110000, 7'b0011001, 7'b0010010,
                                       7'b0000010, 7'b1111000, 7'b0000000,
                                       7'b0010000};
    int          mEdges = 0;
    int          mTicks = 0;
    int          mIdx = 0;
    int          mWraps = 0;
    bit          mBlinkOn = 1'b1;
    bit          mBlank = 1'b0;
    logic [3:0]  mNib = 4'h0;
    logic [23:0] mSnap = 24'h0;
    logic [5:0]  expAn = 6'b111111;
    logic [6:0]  expSeg = 7'b1111111;
    logic        expDp = 1'b1;

    always @(posedge clk or negedge cr) begin
        if (!cr) begin
            mEdges = 0;
            mTicks = 0;
            mSnap  = 24'h0;
            expAn  = 6'b111111;
            expSeg = 7'b1111111;
            expDp  = 1'b1;
        end else begin
            if (mEdges % SCAN_DIV == SCAN_DIV - 1) begin
                mTicks   = mTicks + 1;
                mIdx     = mTicks % 6;
                mWraps   = mTicks / 6;
                if (mIdx == 0) mSnap = {hour, minute, second};
                mNib     = mSnap[4*mIdx +: 4];
                mBlinkOn = ((mWraps / BLINK_FRAMES) % 2) == 0;
                mBlank   = !mBlinkOn && (sel != 2'b00) && ((mIdx / 2 + 1) == int'(sel));
                expAn    = ~(6'b000001 << mIdx);
                expSeg   = mBlank ? 7'b1111111 : ((mNib > 4'd9) ? 7'b0111111 : digitPattern[mNib]);
                expDp    = mBlank ? 1'b1 : !((mIdx == 2) || (mIdx == 4));
            end
            mEdges = mEdges + 1;
        end
    end

    task automatic test_reset();
        #2 cr = 1'b0;
        #1;
        checks++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_async an=%b seg=%b dp=%b want an=111111 seg=1111111 dp=1", an, seg, dp);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_held an=%b seg=%b dp=%b want an=111111 seg=1111111 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_scan();
        hour = 8'h12; minute = 8'h34; second = 8'h56; sel = 2'b00;
        @(negedge clk);
        cr = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL scan c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
            if (c < 3) begin
                checks++;
                if (an !== 6'b111111) begin
                    errors++;
                    $display("[TB] FAIL pre_first_tick c=%0d an=%b want 111111", c, an);
                end
            end else if (c == 3) begin
                checks++;
                if (an !== 6'b111101) begin
                    errors++;
                    $display("[TB] FAIL first_tick an=%b want 111101", an);
                end
            end else if (c == 23) begin
                checks++;
                if (an !== 6'b111110 || seg !== 7'b0000010) begin
                    errors++;
                    $display("[TB] FAIL first_wrap an=%b seg=%b want an=111110 seg=0000010", an, seg);
                end
            end else if (c == 27) begin
                checks++;
                if (an !== 6'b111101 || seg !== 7'b0010010) begin
                    errors++;
                    $display("[TB] FAIL sec_tens_frame2 an=%b seg=%b want an=111101 seg=0010010", an, seg);
                end
            end
        end
    endtask

    task automatic test_snapshot_midframe();
        int guard = 0;
        while ((mTicks % 6) != 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("[TB] FAIL snap_wait_idx3 timeout guard=%0d want <100", guard);
        end
        second = 8'h57;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL snapshot c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
        end
    endtask

    task automatic test_blink();
        int blanked = 0;
        sel = 2'b10;
        for (int c = 0; c < 8 * 6 * SCAN_DIV; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL blink c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
            if (expSeg == 7'b1111111) blanked++;
        end
        checks++;
        if (blanked != 4 * 2 * SCAN_DIV) begin
            errors++;
            $display("[TB] FAIL blink_count blanked=%0d want %0d", blanked, 4 * 2 * SCAN_DIV);
        end
        sel = 2'b00;
    endtask

    task automatic test_dash();
        int t0;
        hour = 8'h2F;
        t0 = mTicks;
        for (int c = 0; c < 3 * 6 * SCAN_DIV; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL dash c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
            if (mTicks > t0 + 6 && (mTicks % 6) == 4) begin
                checks++;
                if (seg !== 7'b0111111 || an !== 6'b101111) begin
                    errors++;
                    $display("[TB] FAIL dash_hr_units an=%b seg=%b want an=101111 seg=0111111", an, seg);
                end
            end
            if (mTicks > t0 + 6 && (mTicks % 6) == 5) begin
                checks++;
                if (seg !== 7'b0100100 || an !== 6'b011111) begin
                    errors++;
                    $display("[TB] FAIL dash_hr_tens an=%b seg=%b want an=011111 seg=0100100", an, seg);
                end
            end
        end
        hour = 8'h12;
    endtask

    task automatic test_reset_midslot();
        int guard = 0;
        while (!((mTicks % 6) == 3 && (mEdges % SCAN_DIV) == 1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("[TB] FAIL rst_wait_idx3 timeout guard=%0d want <100", guard);
        end
        @(posedge clk);
        #2 cr = 1'b0;
        #1;
        checks++;
        if (an !== 6'b111111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_midslot an=%b seg=%b dp=%b want an=111111 seg=1111111 dp=1", an, seg, dp);
        end
        repeat (2) @(negedge clk);
        cr = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL after_reset c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (an !== ((c == 2) ? 6'b111111 : 6'b111101)) begin
                    errors++;
                    $display("[TB] FAIL rst_first_tick c=%0d an=%b want %b", c, an, (c == 2) ? 6'b111111 : 6'b111101);
                end
            end
        end
    endtask

    task automatic test_select_glitch();
        int guard = 0;
        while (!(((mTicks / 6 / BLINK_FRAMES) % 2) == 1 && (mEdges % SCAN_DIV) == 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL glitch_wait timeout guard=%0d want <200", guard);
        end
        sel = 2'b01;
        @(negedge clk);
        sel = 2'b00;
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp || seg === 7'b1111111) begin
                errors++;
                $display("[TB] FAIL sel_glitch c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || dp !== expDp) begin
                errors++;
                $display("[TB] FAIL random c=%0d an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", c, an, seg, dp, expAn, expSeg, expDp);
            end
            if ($urandom_range(7) == 0) begin
                hour   = 8'($urandom);
                minute = 8'($urandom);
                second = 8'($urandom);
            end
            if ($urandom_range(11) == 0) sel = 2'($urandom);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot_midframe();
        test_blink();
        test_dash();
        test_reset_midslot();
        test_select_glitch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
